// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared types and constants for the bit-serial subtractor slice.
package serial_subtractor_pkg;

  // Control states of the serial subtractor.
  //   IDLE : waiting for operands, in_ready high
  //   RUN  : one difference bit per clock, LSB first
  //   DONE : result presented until the consumer accepts it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Two's-complement overflow of a - b.
  // Overflow is only possible when the operand signs differ. It happened
  // when the sign of the difference disagrees with the sign of the minuend.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Operand handshake, result handshake and serial debug tap of the
// bit-serial subtractor. The producer/consumer side uses the master modport;
// the subtractor itself uses the slave modport.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;

  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  // serial observation tap
  logic             bit_valid;
  logic             bit_out;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, bit_valid, bit_out
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, bit_valid, bit_out
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// Single-bit full subtractor: computes x - y - z, producing the difference
// bit d and the borrow-out bo. This is the only arithmetic cell of the
// serial subtractor; it is reused for every bit position over time.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out of one bit position.
  always_comb begin
    d  = x ^ y ^ z;
    bo = (~x & y) | (~x & z) | (y & z);
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands are latched on an accepted valid/ready handshake, WIDTH RUN cycles
// produce the difference bits, and the result is then held on the output
// handshake until the consumer takes it.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave sub
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result;
  logic             borrow;
  logic [1:0]       msb_q;
  logic             fs_d;
  logic             fs_bo;

  // The one arithmetic cell, fed from the operand LSBs and the borrow flop.
  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .z  (borrow),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Control FSM plus the whole datapath: operand shifters, result shifter,
  // borrow flop, bit counter and the captured operand sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      result <= '0;
      borrow <= 1'b0;
      msb_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (sub.in_valid) begin
            a_sr   <= sub.a;
            b_sr   <= sub.b;
            borrow <= sub.bin;
            cnt    <= '0;
            result <= '0;
            msb_q  <= {sub.a[WIDTH-1], sub.b[WIDTH-1]};
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {fs_d, result[WIDTH-1:1]};
          borrow <= fs_bo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (sub.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state. Result fields are forced to zero
  // outside DONE so nothing partial is ever visible on the result side.
  always_comb begin
    sub.in_ready  = 1'b0;
    sub.out_valid = 1'b0;
    sub.diff      = '0;
    sub.bout      = 1'b0;
    sub.ovf       = 1'b0;
    sub.bit_valid = 1'b0;
    sub.bit_out   = 1'b0;
    case (state)
      IDLE: begin
        sub.in_ready = 1'b1;
      end
      RUN: begin
        sub.bit_valid = 1'b1;
        sub.bit_out   = fs_d;
      end
      DONE: begin
        sub.out_valid = 1'b1;
        sub.diff      = result;
        sub.bout      = borrow;
        sub.ovf       = signed_ovf(msb_q[1], msb_q[0], result[WIDTH-1]);
      end
      default: begin
        sub.in_ready = 1'b0;
      end
    endcase
  end

endmodule
